// File: rtl/note_led_bar_if.sv
// rtl/note_led_bar_if.sv - octave digit inputs, brightness and LED bar outputs of note_led_bar
interface note_led_bar_if #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 4
);
  logic [3:0]          high;
  logic [3:0]          med;
  logic [3:0]          low;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] led;
  logic [4:0]          note_idx;
  logic                active;

  modport master (
    output high, med, low, brightness,
    input  led, note_idx, active
  );

  modport slave (
    input  high, med, low, brightness,
    output led, note_idx, active
  );
endinterface

// File: rtl/note_led_bar.sv
// rtl/note_led_bar.sv - note-indicator LED bar: jump to note level, hold, decay one LED at a time
// Optional PWM dimming of lit LEDs when NOTE_LED_BAR_PWM_EN is defined.
module note_led_bar #(
  parameter int NUM_LEDS     = 8,
  parameter int HOLD_CYCLES  = 2500000,
  parameter int DECAY_CYCLES = 1250000,
  parameter int PWM_BITS     = 4
) (
  input  logic          clk,
  input  logic          rst,
  note_led_bar_if.slave bus
);

  localparam int BAR_W   = $clog2(NUM_LEDS + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int DECAY_W = $clog2(DECAY_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

  state_t              state_q, state_d;
  logic [11:0]         in_q, prev_q;
  logic [BAR_W-1:0]    bar_q, bar_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DECAY_W-1:0]  decay_q, decay_d;
  logic [4:0]          idx_q, idx_d;
  logic [NUM_LEDS-1:0] led_q, therm;

  logic [3:0]       hi_d, md_d, lo_d;
  logic             dec_valid, dec_rest, changed, note_ev, rest_ev;
  logic [4:0]       dec_idx;
  logic [9:0]       lvl_num;
  logic [BAR_W-1:0] lvl;
  logic             gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q   <= '0;
      prev_q <= '0;
    end else begin
      in_q   <= {bus.high, bus.med, bus.low};
      prev_q <= in_q;
    end
  end

  // Exactly one nonzero digit in 1..7 is a note; everything else but all-zero is ignored.
  always_comb begin
    hi_d      = in_q[11:8];
    md_d      = in_q[7:4];
    lo_d      = in_q[3:0];
    dec_valid = 1'b0;
    dec_rest  = 1'b0;
    dec_idx   = 5'd0;
    if (in_q == 12'd0) begin
      dec_valid = 1'b1;
      dec_rest  = 1'b1;
    end else if (hi_d == 4'd0 && md_d == 4'd0 && lo_d <= 4'd7) begin
      dec_valid = 1'b1;
      dec_idx   = {1'b0, lo_d};
    end else if (hi_d == 4'd0 && lo_d == 4'd0 && md_d <= 4'd7) begin
      dec_valid = 1'b1;
      dec_idx   = 5'd7 + {1'b0, md_d};
    end else if (md_d == 4'd0 && lo_d == 4'd0 && hi_d <= 4'd7) begin
      dec_valid = 1'b1;
      dec_idx   = 5'd14 + {1'b0, hi_d};
    end
  end

  assign changed = (in_q != prev_q);
  assign note_ev = dec_valid && !dec_rest && changed;
  assign rest_ev = dec_rest && changed;
  assign lvl_num = 10'(dec_idx) * 10'(NUM_LEDS) + 10'd20;
  assign lvl     = BAR_W'(lvl_num / 10'd21);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bar_q   <= '0;
      hold_q  <= '0;
      decay_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bar_q   <= bar_d;
      hold_q  <= hold_d;
      decay_q <= decay_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bar_d   = bar_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: ;
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = DECAY;
          decay_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DECAY: begin
        if (bar_q == '0) begin
          state_d = IDLE;
        end else if (decay_q == DECAY_W'(DECAY_CYCLES - 1)) begin
          decay_d = '0;
          bar_d   = bar_q - 1'b1;
          if (bar_q == BAR_W'(1)) state_d = IDLE;
        end else begin
          decay_d = decay_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh note overrides any hold expiry or decay step in the same cycle.
    if (note_ev) begin
      bar_d   = lvl;
      idx_d   = dec_idx;
      hold_d  = '0;
      state_d = HOLD;
    end else if (dec_rest) begin
      idx_d = 5'd0;
      if (rest_ev && state_q == HOLD) begin
        state_d = DECAY;
        decay_d = '0;
      end
    end
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_LEDS; i++) therm[i] = (BAR_W'(i) < bar_q);
  end

`ifdef NOTE_LED_BAR_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign gate = (pwm_cnt < bus.brightness) || (&bus.brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= therm & {NUM_LEDS{gate}};
  end

  assign bus.led      = led_q;
  assign bus.note_idx = idx_q;
  assign bus.active   = (state_q != IDLE);

endmodule

// File: tb/tb_note_led_bar.sv
// tb/tb_note_led_bar.sv - scoreboard bench for note_led_bar (8 LEDs, hold 4, decay 2)
module tb_note_led_bar;

  localparam int NL  = 8;
  localparam int HC  = 4;
  localparam int DC  = 2;
  localparam int PB  = 4;

  typedef struct {
    logic [7:0] led;
    logic [4:0] idx;
    logic       act;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  note_led_bar_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus ();

  note_led_bar #(
    .NUM_LEDS(NL), .HOLD_CYCLES(HC), .DECAY_CYCLES(DC), .PWM_BITS(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int bar_at(input int x, input int old_bar, input int lvl, input int hold);
    int v;
    if (x <= 0) return old_bar;
    if (x - 1 < hold) return lvl;
    v = lvl - (x - 1 - hold) / DC;
    return (v < 0) ? 0 : v;
  endfunction

  // Expected outputs sampled after edge e, where edge 0 is the first edge to register the new input.
  task automatic push_trace(input int old_bar, input int lvl, input int new_idx,
                            input int old_idx, input int hold, input int n);
    exp_t r;
    for (int e = 0; e < n; e++) begin
      r.led = 8'(((1 << bar_at(e - 1, old_bar, lvl, hold)) - 1) & 8'hFF);
      r.idx = 5'((e == 0) ? old_idx : new_idx);
      r.act = (bar_at(e, old_bar, lvl, hold) != 0);
      sbq.push_back(r);
    end
  endtask

  task automatic test_reset();
    exp_t x;
    bus.high = 4'd0; bus.med = 4'd0; bus.low = 4'd0; bus.brightness = 4'd15;
    #1;
    total++;
    if ({bus.led, bus.note_idx, bus.active} !== 14'd0)
      $display("FAIL reset_asserted led=%h idx=%0d act=%b expected all zero", bus.led, bus.note_idx, bus.active);
    else passed++;
    repeat (3) step();
    rst = 1'b0;
    push_trace(0, 0, 0, 0, 0, 20);
    for (int i = 0; i < 20; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL reset_idle c=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
  endtask

  task automatic test_full_scale();
    exp_t x;
    bus.high = 4'd7;
    push_trace(0, 8, 21, 0, HC, 25);
    for (int i = 0; i < 25; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL full_scale e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    bus.high = 4'd0;
    repeat (3) step();
  endtask

  task automatic test_retarget();
    exp_t x;
    bus.low = 4'd7;
    push_trace(0, 3, 7, 0, HC, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL retarget_low e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    bus.low = 4'd0; bus.med = 4'd7;
    push_trace(3, 6, 14, 7, HC, 3);
    bus.med = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL retarget_med e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    bus.med = 4'd0;
    push_trace(6, 6, 0, 14, 0, 16);
    for (int i = 0; i < 16; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL retarget_rest e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
  endtask

  task automatic test_steady_invalid();
    exp_t x;
    bus.low = 4'd1;
    push_trace(0, 1, 1, 0, HC, 40);
    for (int i = 0; i < 40; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL steady e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin bus.high = 4'd0; bus.med = 4'd2; bus.low = 4'd3; end
        1: begin bus.high = 4'd9; bus.med = 4'd0; bus.low = 4'd0; end
        default: begin bus.high = 4'd0; bus.med = 4'd0; bus.low = 4'd0; end
      endcase
      push_trace(0, 0, (k == 2) ? 0 : 1, 1, 0, 8);
      for (int i = 0; i < 8; i++) begin
        step();
        x = sbq.pop_front();
        total++;
        if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
          $display("FAIL invalid k=%0d e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                   k, i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_decay();
    exp_t x;
    bus.med = 4'd1;
    push_trace(0, 4, 8, 0, HC, 7);
    for (int i = 0; i < 7; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL pre_reset e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    bus.med = 4'd0; bus.high = 4'd7; rst = 1'b1;
    #1;
    total++;
    if ({bus.led, bus.note_idx, bus.active} !== 14'd0)
      $display("FAIL mid_reset_async led=%h idx=%0d act=%b expected all zero", bus.led, bus.note_idx, bus.active);
    else passed++;
    step();
    step();
    total++;
    if ({bus.led, bus.note_idx, bus.active} !== 14'd0)
      $display("FAIL mid_reset_held led=%h idx=%0d act=%b expected all zero", bus.led, bus.note_idx, bus.active);
    else passed++;
    rst = 1'b0;
    push_trace(0, 8, 21, 0, HC, 10);
    for (int i = 0; i < 10; i++) begin
      step();
      x = sbq.pop_front();
      total++;
      if ({bus.led, bus.note_idx, bus.active} !== {x.led, x.idx, x.act})
        $display("FAIL post_reset e=%0d led=%h idx=%0d act=%b expected led=%h idx=%0d act=%b",
                 i, bus.led, bus.note_idx, bus.active, x.led, x.idx, x.act);
      else passed++;
    end
    bus.high = 4'd0;
    repeat (30) step();
  endtask

  // Alternating high=7/high=6 keeps re-striking level 8, so the bar stays full while duty is measured.
  task automatic test_pwm();
    int ones, bad, expect_ones;
    for (int p = 0; p < 2; p++) begin
      bus.brightness = (p == 0) ? 4'd4 : 4'd15;
      ones = 0;
      bad  = 0;
      for (int i = 0; i < 20; i++) begin
        bus.high = (i % 2 == 0) ? 4'd7 : 4'd6;
        step();
        if (i >= 4) begin
          if (bus.led == 8'hFF) ones++;
          else if (bus.led != 8'h00) bad++;
        end
      end
`ifdef NOTE_LED_BAR_PWM_EN
      expect_ones = (p == 0) ? 4 : 16;
`else
      expect_ones = 16;
`endif
      total++;
      if (ones !== expect_ones)
        $display("FAIL pwm_duty brightness=%0d lit_cycles=%0d expected %0d", bus.brightness, ones, expect_ones);
      else passed++;
      total++;
      if (bad !== 0)
        $display("FAIL pwm_partial brightness=%0d partial_bar_cycles=%0d expected 0", bus.brightness, bad);
      else passed++;
    end
    bus.high = 4'd0;
    repeat (25) step();
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_retarget();
    test_steady_invalid();
    test_reset_mid_decay();
    test_pwm();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/note_led_bar.md
# note_led_bar

Parametrised note-indicator driver for the MP3/music player front panel. Decodes the three 4-bit octave digits (high/med/low) produced by the tone decoder into a note index 0..21 and drives an active-high LED bar graph of configurable length. Bar jumps to the note's level, holds, then decays one LED at a time. Optional PWM dimming of the lit LEDs.

## Interface
- NUM_LEDS, 8: number of bar LEDs, 2..21.
- HOLD_CYCLES, 2500000: clocks the bar is held after a note event, ≥1.
- DECAY_CYCLES, 1250000: clocks per one-LED decrement during decay, ≥1.
- PWM_BITS, 4: brightness/PWM counter width, 1..8.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- high  in  4  high-octave digit, 0 = none, 1..7 = note.
- med  in  4  middle-octave digit, same coding.
- low  in  4  low-octave digit, same coding.
- brightness  in  PWM_BITS  LED duty; all-ones = fully on; used only with PWM macro.
- led  out  NUM_LEDS  bar, bit 0 = bottom LED, 1 = lit.
- note_idx  out  5  index of last accepted note, 0 = rest.
- active  out  1  high when state ≠ IDLE.

## Operation
- Input register in_q <= {high,med,low} every clock; prev_q <= in_q every clock.
- Decode of in_q (combinational): all zero → rest, idx 0. Exactly one digit nonzero and in 1..7 → low: idx = d; med: idx = 7+d; high: idx = 14+d. Any other code (two+ digits nonzero, or digit 8..15) → invalid, ignored entirely.
- Note event: in_q decodes valid, non-rest, and in_q ≠ prev_q. Steady input never retriggers; the same note re-strikes only after an intervening different code.
- Level: lvl = (idx*NUM_LEDS + 20) / 21, integer; intermediate width ≥ 10 bits; idx 0 → 0, idx 21 → NUM_LEDS.
- bar: register 0..NUM_LEDS, width $clog2(NUM_LEDS+1).
- States:
  - IDLE: bar = 0. Note event → HOLD.
  - HOLD: hold counter counts HOLD_CYCLES clocks → DECAY.
  - DECAY: every DECAY_CYCLES clocks bar decrements by 1; bar reaching 0 → IDLE.
- Note event in any state: bar <= lvl (up or down), note_idx <= idx, hold counter cleared, → HOLD. Takes priority over a same-cycle hold expiry or decay step.
- Rest code becoming present (in_q changes to all zero) in HOLD: → DECAY immediately, decay counter cleared; note_idx <= 0. In IDLE/DECAY rest has no effect besides note_idx <= 0.
- Invalid codes: no state, bar or note_idx change; counters keep running.
- led <= thermometer(bar) ANDed with PWM gate (see Configuration), registered.

## Timing
- Reset (async, immediate): led = 0, note_idx = 0, active = 0, bar = 0, state IDLE, all counters 0, in_q = prev_q = 0.
- Latency: input stable before edge E0 → bar/note_idx/state updated at E1 → led updated at E2 (2 clocks).
- HOLD lasts exactly HOLD_CYCLES clocks; first decrement occurs DECAY_CYCLES clocks after DECAY entry; led follows bar one clock later.
- Reset asserted mid-hold or mid-decay: all outputs zero while asserted; after release, a still-present note is a new event (in_q ≠ prev_q = 0 on first sample).

## Configuration
- NOTE_LED_BAR_PWM_EN defined: free-running PWM_BITS counter; gate = (cnt < brightness) or (brightness = all-ones); lit LEDs pulse at that duty, unlit stay 0.
- Not defined: gate = 1; brightness ignored; no PWM counter synthesised; led is pure thermometer.

## Test plan
Bench parameters NUM_LEDS=8, HOLD_CYCLES=4, DECAY_CYCLES=2, PWM_BITS=4.
- Reset release, inputs 0 → led=0x00, note_idx=0, active=0 for 20 clocks.
- high=7 for 1+ clocks → note_idx=21, led=0xFF at E2; held 4 clocks, then 0x7F, 0x3F … each 2 clocks apart, 0x00 and active=0 after 16 decay clocks.
- low=7 → note_idx=7, led=0x07; switch to med=7 during HOLD → note_idx=14, led=0x3F, hold restarts; then rest → decay starts next clock.
- low=1 held steady 40 clocks → single event (led=0x01 then decays to 0, no retrigger); low=3,med=2 together → no change.
- rst pulsed mid-decay with led=0x0F → led=0x00 immediately; after release with high=7 still applied → led=0xFF 2 clocks later.
- With NOTE_LED_BAR_PWM_EN, brightness=4, high=7 → each led bit high 4 of every 16 clocks during hold; brightness=15 → continuously 0xFF.
